// File: rtl/neuron_mac_ctrl.sv
// Single-neuron MAC controller: walks the weight/activation BRAMs, accumulates
// Q8.8 products, adds the bias, applies ReLU and saturation, emits one result per START.
module neuron_mac_ctrl #(
    parameter int N_INPUTS  = 28,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ADDR_W    = 5,
    parameter int ACC_W     = 40
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic signed [DATA_W-1:0] i_bias,
    input  logic signed [DATA_W-1:0] i_w_do,
    input  logic signed [DATA_W-1:0] i_x_do,
    output logic                     o_mem_en,
    output logic        [ADDR_W-1:0] o_mem_addr,
    output logic                     o_busy,
    output logic        [DATA_W-1:0] o_y_out,
    output logic                     o_y_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FINISH
    } state_t;

    localparam logic        [ADDR_W-1:0] LAST_RUN_ADDR = ADDR_W'(N_INPUTS - 2);
    localparam logic signed [ACC_W-1:0]  Y_MAX         = ACC_W'((1 << (DATA_W - 1)) - 1);

    state_t                    r_state;
    logic signed [ACC_W-1:0]   r_acc;
    logic        [ADDR_W-1:0]  r_addr;
    logic                      r_mem_en;
    logic                      r_busy;
    logic        [DATA_W-1:0]  r_y_out;
    logic                      r_y_valid;

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_bias_sh;
    logic signed [ACC_W-1:0]    w_sum;

    // Drop the fraction (floor), clamp negatives to zero and large values to full scale
    function automatic logic [DATA_W-1:0] relu_sat(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] r;
        r = s >>> FRAC_BITS;
        if (r < 0)
            relu_sat = '0;
        else if (r > Y_MAX)
            relu_sat = Y_MAX[DATA_W-1:0];
        else
            relu_sat = r[DATA_W-1:0];
    endfunction

    assign w_prod     = i_w_do * i_x_do;
    assign w_prod_ext = {{(ACC_W - 2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_bias_sh  = {{(ACC_W - DATA_W){i_bias[DATA_W-1]}}, i_bias} <<< FRAC_BITS;
    assign w_sum      = r_acc + w_bias_sh;

    // Read data always belongs to the address issued one edge earlier
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_addr    <= '0;
            r_mem_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_y_out   <= '0;
            r_y_valid <= 1'b0;
        end else begin
            r_y_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_acc    <= '0;
                        r_addr   <= '0;
                        r_mem_en <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc  <= r_acc + w_prod_ext;
                    r_addr <= r_addr + 1'b1;
                    if (r_addr == LAST_RUN_ADDR)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_acc    <= r_acc + w_prod_ext;
                    r_mem_en <= 1'b0;
                    r_state  <= S_FINISH;
                end
                S_FINISH: begin
                    r_y_out   <= relu_sat(w_sum);
                    r_y_valid <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_en   = r_mem_en;
    assign o_mem_addr = r_addr;
    assign o_busy     = r_busy;
    assign o_y_out    = r_y_out;
    assign o_y_valid  = r_y_valid;

endmodule
